// File: rtl/vga_axil_slave_ctrl.sv
// AXI-Lite slave bridging to a native register port: one-cycle write/read strobes, reads use a 1-cycle native latency.
// Each channel accepts one transaction at a time and holds B/R until bready_i/rready_i; AW/W/AR stall meanwhile.
module vga_axil_slave_ctrl #(
  parameter int AXIL_ADDR_WIDTH = 32,
  parameter int AXIL_DATA_WIDTH = 32,
  parameter int REG_COUNT       = 16,
  parameter logic [AXIL_ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int WR_PRIORITY     = 1,
  localparam int NA = $clog2(REG_COUNT),
  localparam int SW = AXIL_DATA_WIDTH / 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [AXIL_ADDR_WIDTH-1:0] awaddr_i,
  input  logic                       awvalid_i,
  output logic                       awready_o,
  input  logic [AXIL_DATA_WIDTH-1:0] wdata_i,
  input  logic [SW-1:0]              wstrb_i,
  input  logic                       wvalid_i,
  output logic                       wready_o,
  output logic [1:0]                 bresp_o,
  output logic                       bvalid_o,
  input  logic                       bready_i,
  input  logic [AXIL_ADDR_WIDTH-1:0] araddr_i,
  input  logic                       arvalid_i,
  output logic                       arready_o,
  output logic [AXIL_DATA_WIDTH-1:0] rdata_o,
  output logic [1:0]                 rresp_o,
  output logic                       rvalid_o,
  input  logic                       rready_i,
  output logic                       write_en_o,
  output logic [NA-1:0]              addr_write_o,
  output logic [AXIL_DATA_WIDTH-1:0] data_o,
  output logic [SW-1:0]              strb_o,
  output logic                       read_en_o,
  output logic [NA-1:0]              addr_read_o,
  input  logic [AXIL_DATA_WIDTH-1:0] data_i
);

  localparam int AL = $clog2(SW);
  localparam int WW = AXIL_ADDR_WIDTH - AL;
  localparam logic [WW-1:0] LP_REG_COUNT = WW'(REG_COUNT);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {W_IDLE, W_ADDR, W_DATA, W_EXEC, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_RESP} rstate_t;

  wstate_t r_wstate;
  rstate_t r_rstate;
  logic    r_aw_ok;
  logic    r_ar_ok;

  // Extra top bit of the offset is the borrow: set when the address lies below BASE_ADDR.
  logic [AXIL_ADDR_WIDTH:0] w_aw_off;
  logic [AXIL_ADDR_WIDTH:0] w_ar_off;
  logic                     w_aw_ok;
  logic                     w_ar_ok;
  logic [NA-1:0]            w_aw_idx;
  logic [NA-1:0]            w_ar_idx;
  logic                     w_rd_hold;
  logic                     w_unused;

  assign w_aw_off = {1'b0, awaddr_i} - {1'b0, BASE_ADDR};
  assign w_ar_off = {1'b0, araddr_i} - {1'b0, BASE_ADDR};
  assign w_aw_ok  = !w_aw_off[AXIL_ADDR_WIDTH] && (w_aw_off[AXIL_ADDR_WIDTH-1:AL] < LP_REG_COUNT);
  assign w_ar_ok  = !w_ar_off[AXIL_ADDR_WIDTH] && (w_ar_off[AXIL_ADDR_WIDTH-1:AL] < LP_REG_COUNT);
  assign w_aw_idx = w_aw_off[AL+NA-1:AL];
  assign w_ar_idx = w_ar_off[AL+NA-1:AL];
  assign w_unused = ^{w_aw_off[AL-1:0], w_ar_off[AL-1:0]};

  // Delaying the read one cycle makes the native read observe the colliding write.
  assign w_rd_hold = (WR_PRIORITY != 0) && (r_wstate == W_EXEC) && r_aw_ok && r_ar_ok &&
                     (addr_write_o == addr_read_o);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wstate     <= W_IDLE;
      r_aw_ok      <= 1'b0;
      awready_o    <= 1'b1;
      wready_o     <= 1'b1;
      bvalid_o     <= 1'b0;
      bresp_o      <= RESP_OKAY;
      write_en_o   <= 1'b0;
      addr_write_o <= '0;
      data_o       <= '0;
      strb_o       <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (awvalid_i) begin
            r_aw_ok      <= w_aw_ok;
            addr_write_o <= w_aw_idx;
            awready_o    <= 1'b0;
          end
          if (wvalid_i) begin
            data_o   <= wdata_i;
            strb_o   <= wstrb_i;
            wready_o <= 1'b0;
          end
          if (awvalid_i && wvalid_i) r_wstate <= W_EXEC;
          else if (awvalid_i)        r_wstate <= W_DATA;
          else if (wvalid_i)         r_wstate <= W_ADDR;
        end
        W_ADDR: begin
          if (awvalid_i) begin
            r_aw_ok      <= w_aw_ok;
            addr_write_o <= w_aw_idx;
            awready_o    <= 1'b0;
            r_wstate     <= W_EXEC;
          end
        end
        W_DATA: begin
          if (wvalid_i) begin
            data_o   <= wdata_i;
            strb_o   <= wstrb_i;
            wready_o <= 1'b0;
            r_wstate <= W_EXEC;
          end
        end
        W_EXEC: begin
          write_en_o <= r_aw_ok;
          bvalid_o   <= 1'b1;
          bresp_o    <= r_aw_ok ? RESP_OKAY : RESP_DECERR;
          r_wstate   <= W_RESP;
        end
        W_RESP: begin
          write_en_o <= 1'b0;
          if (bready_i) begin
            bvalid_o  <= 1'b0;
            bresp_o   <= RESP_OKAY;
            strb_o    <= '0;
            awready_o <= 1'b1;
            wready_o  <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rstate    <= R_IDLE;
      r_ar_ok     <= 1'b0;
      arready_o   <= 1'b1;
      rvalid_o    <= 1'b0;
      rresp_o     <= RESP_OKAY;
      rdata_o     <= '0;
      read_en_o   <= 1'b0;
      addr_read_o <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (arvalid_i) begin
            r_ar_ok     <= w_ar_ok;
            addr_read_o <= w_ar_idx;
            arready_o   <= 1'b0;
            r_rstate    <= R_ISSUE;
          end
        end
        R_ISSUE: begin
          if (!r_ar_ok) begin
            rdata_o  <= '0;
            rresp_o  <= RESP_DECERR;
            rvalid_o <= 1'b1;
            r_rstate <= R_RESP;
          end else if (!w_rd_hold) begin
            read_en_o <= 1'b1;
            r_rstate  <= R_WAIT;
          end
        end
        R_WAIT: begin
          // read_en_o doubles as the phase bit: data_i is valid the cycle after it drops.
          if (read_en_o) begin
            read_en_o <= 1'b0;
          end else begin
            rdata_o  <= data_i;
            rresp_o  <= RESP_OKAY;
            rvalid_o <= 1'b1;
            r_rstate <= R_RESP;
          end
        end
        R_RESP: begin
          if (rready_i) begin
            rvalid_o  <= 1'b0;
            arready_o <= 1'b1;
            r_rstate  <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: doc/vga_axil_slave_ctrl.md
VGA_AXIL_SLAVE_CTRL -- requirements
Module: vga_axil_slave_ctrl

Interface
REQ-001 SHALL have parameter AXIL_ADDR_WIDTH, default 32, AXI-Lite address width.
REQ-002 SHALL have parameter AXIL_DATA_WIDTH, default 32, data width; only 32 or 64 are legal.
REQ-003 SHALL have parameter REG_COUNT, default 16, number of native word registers; must be at least 2.
REQ-004 SHALL have parameter BASE_ADDR, default 0, byte address of register 0; aligned to AXIL_DATA_WIDTH/8.
REQ-005 SHALL have parameter WR_PRIORITY, default 1; 1 = write wins a same-cycle native collision, 0 = no arbitration.
REQ-006 Ports (NA = clog2(REG_COUNT), DW = AXIL_DATA_WIDTH, SW = DW/8):
- clk_i  in  1  clock; one clock domain, all logic rising-edge.
- rst_i  in  1  reset; synchronous, active-high.
- awaddr_i/awvalid_i/awready_o  in/in/out  AXIL_ADDR_WIDTH/1/1  write-address channel.
- wdata_i/wstrb_i/wvalid_i/wready_o  in/in/in/out  DW/SW/1/1  write-data channel.
- bresp_o/bvalid_o/bready_i  out/out/in  2/1/1  write-response channel.
- araddr_i/arvalid_i/arready_o  in/in/out  AXIL_ADDR_WIDTH/1/1  read-address channel.
- rdata_o/rresp_o/rvalid_o/rready_i  out/out/out/in  DW/2/1/1  read-data channel.
- write_en_o/addr_write_o/data_o/strb_o  out  1/NA/DW/SW  native write strobe, word index, data, byte enables.
- read_en_o/addr_read_o  out  1/NA  native read strobe, word index.
- data_i  in  DW  native read data; valid exactly one cycle after read_en_o.

Function
REQ-007 Word index SHALL be (addr - BASE_ADDR) >> clog2(SW); the low clog2(SW) address bits are ignored.
REQ-008 An address below BASE_ADDR, or with index >= REG_COUNT, SHALL give resp DECERR (2'b11) and SHALL NOT pulse a native strobe; valid addresses give OKAY (2'b00).
REQ-009 Write FSM states SHALL be W_IDLE, W_ADDR (data held, waiting for address), W_DATA (address held, waiting for data), W_EXEC and W_RESP.
REQ-010 In W_IDLE, awready_o and wready_o SHALL both be high.
- AW and W handshake in the same cycle -> W_EXEC.
- AW handshake only -> W_DATA, with only wready_o high.
- W handshake only -> W_ADDR, with only awready_o high.
REQ-011 W_EXEC SHALL last one cycle.
- write_en_o pulses for exactly that cycle when the address is valid, carrying the latched index, data and strobes.
- The FSM then enters W_RESP.
REQ-012 In W_RESP, bvalid_o SHALL be high with bresp_o stable until the bready_i handshake; then W_IDLE.
REQ-013 Back-to-back writes SHALL be accepted in the cycle after the B handshake; a B handshake is at least 2 cycles after the AW/W handshake.
REQ-014 Read FSM states SHALL be R_IDLE, R_ISSUE, R_WAIT and R_RESP; arready_o is high only in R_IDLE.
REQ-015 AR handshake SHALL latch the address and move to R_ISSUE.
REQ-016 R_ISSUE behaviour:
- Pulses read_en_o for a valid address, then R_WAIT.
- For an invalid address, goes straight to R_RESP with rdata_o = 0 and DECERR.
REQ-017 R_WAIT SHALL capture data_i into rdata_o and go to R_RESP.
REQ-018 In R_RESP, rvalid_o SHALL be high with rdata_o/rresp_o stable until the rready_i handshake; then R_IDLE.
REQ-019 Read and write FSMs SHALL run independently and concurrently.
REQ-020 Collision handling when WR_PRIORITY=1:
- A collision is R_ISSUE and W_EXEC in the same cycle, both valid, same index.
- read_en_o SHALL be held off one cycle so that data_i reflects the new write.
- With different indices, or WR_PRIORITY=0, both strobes fire in the same cycle.
REQ-021 write_en_o and read_en_o SHALL never be high for more than one consecutive cycle per transaction.
REQ-022 Data and strobes SHALL pass through without modification; all stored strobe state is cleared on every return to idle.

Reset
REQ-023 With rst_i high at a clock edge, the next state SHALL be as follows.
- Both FSMs in idle.
- awready_o, wready_o, arready_o = 1.
- bvalid_o, rvalid_o, write_en_o, read_en_o = 0.
- bresp_o, rresp_o, rdata_o, addr_write_o, addr_read_o, data_o, strb_o = 0.
REQ-024 Reset asserted mid-transaction SHALL abort the transaction.
- The abort is silent: no native strobe and no response is issued afterwards.
- A pending bvalid_o/rvalid_o is dropped.

Verification
REQ-025 Defaults, write 0x4 data 0xDEADBEEF strb 0xF: write_en_o for 1 cycle, addr_write_o=1, data_o=0xDEADBEEF; bresp=OKAY.
REQ-026 Read of 0x4 with a native model returning the stored value: read_en_o for 1 cycle, addr_read_o=1; rdata=0xDEADBEEF, rresp=OKAY.
REQ-027 W handshake 3 cycles before AW, then the reverse order: each gives exactly one write_en_o with the correct index/data; bvalid held high with bready low for 5 cycles and stays stable.
REQ-028 Write to 0x40 (index 16) and read of 0x40: no native strobe; bresp=DECERR; rresp=DECERR; rdata=0.
REQ-029 WR_PRIORITY=1, write 0x8 data 0x12345678 issued in the same cycle as a read of 0x8: read_en_o one cycle after write_en_o; rdata=0x12345678.
REQ-030 rst_i pulsed in the cycle after the AW/W handshake: no write_en_o, no bvalid_o; all outputs at their reset values; the next write completes normally.
